// File: rtl/pc_npc_sequencer_pkg.sv
// Shared decode constants and state encoding for the PC/nPC sequencer.
// Imported by the sequencer top and its branch resolver.
package pc_npc_sequencer_pkg;

    localparam logic [1:0] OP_BR    = 2'b00;
    localparam logic [1:0] OP_CALL  = 2'b01;
    localparam logic [2:0] OP2_BICC = 3'b010;
    localparam logic [3:0] COND_BN  = 4'b0000;
    localparam logic [3:0] COND_BA  = 4'b1000;

    typedef enum logic [2:0] {
        ST_START,
        ST_FETCH,
        ST_EXEC,
        ST_SQUASH,
        ST_HALT
    } state_t;

    function automatic logic is_bicc(input logic [31:0] ir);
        return (ir[31:30] == OP_BR) && (ir[24:22] == OP2_BICC);
    endfunction

endpackage

// File: rtl/pc_npc_sequencer_branch_resolver.sv
// Bicc outcome: whether the branch is taken and whether its delay slot is annulled.
// Both outputs are low for any instruction that is not a Bicc.
module pc_npc_sequencer_branch_resolver
    import pc_npc_sequencer_pkg::*;
(
    input  logic [31:0] ir,
    input  logic        cond_true,
    output logic        taken,
    output logic        annul_delay
);

    logic [3:0] cond;
    logic       annul;
    logic       bicc;
    logic       unused_ir;

    assign cond      = ir[28:25];
    assign annul     = ir[29];
    assign bicc      = is_bicc(ir);
    assign unused_ir = ^ir[21:0];

    // BA/BN annul on the a bit alone; conditional branches annul only when not taken
    always_comb begin
        taken       = 1'b0;
        annul_delay = 1'b0;
        if (bicc) begin
            if (cond == COND_BA) begin
                taken       = 1'b1;
                annul_delay = annul;
            end else if (cond == COND_BN) begin
                taken       = 1'b0;
                annul_delay = annul;
            end else begin
                taken       = cond_true;
                annul_delay = annul & ~cond_true;
            end
        end
    end

endmodule

// File: rtl/pc_npc_sequencer.sv
// SPARC-style PC/nPC sequencer: fetch handshake, delayed branches, annulled delay
// slots, CALL/JMPL redirection and a sticky halt on misaligned JMPL targets.
module pc_npc_sequencer
    import pc_npc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] RESET_NPC = 32'h0000_0004
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] Disp,
    input  logic [31:0] IR,
    input  logic        CondTrue,
    input  logic        TakeJmpl,
    input  logic [31:0] JmplTarget,
    input  logic        Advance,
    input  logic        MemReady,
    output logic        MemReq,
    output logic [31:0] FetchAddr,
    output logic        IRLoad,
    output logic [31:0] PC,
    output logic [31:0] nPC,
    output logic        Misalign
);

    state_t      state;
    logic        annul_pend;
    logic        br_taken;
    logic        br_annul;
    logic [31:0] seq_npc;
    logic [31:0] target;

    pc_npc_sequencer_branch_resolver u_branch_resolver (
        .ir          (IR),
        .cond_true   (CondTrue),
        .taken       (br_taken),
        .annul_delay (br_annul)
    );

    assign seq_npc   = nPC + 32'd4;
    assign target    = PC + Disp;
    assign MemReq    = (state == ST_FETCH);
    assign FetchAddr = PC;
    assign IRLoad    = (state == ST_FETCH) & MemReady & ~annul_pend;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            PC         <= RESET_PC;
            nPC        <= RESET_NPC;
            annul_pend <= 1'b0;
            Misalign   <= 1'b0;
            state      <= ST_START;
        end else begin
            case (state)
                ST_START: state <= ST_FETCH;
                ST_FETCH: begin
                    if (MemReady) state <= annul_pend ? ST_SQUASH : ST_EXEC;
                end
                // The annulled delay slot is stepped over without ever reaching IR
                ST_SQUASH: begin
                    PC         <= nPC;
                    nPC        <= seq_npc;
                    annul_pend <= 1'b0;
                    state      <= ST_FETCH;
                end
                ST_EXEC: begin
                    if (Advance) begin
                        if (TakeJmpl && (JmplTarget[1:0] != 2'b00)) begin
                            Misalign <= 1'b1;
                            state    <= ST_HALT;
                        end else begin
                            PC    <= nPC;
                            state <= ST_FETCH;
                            if (TakeJmpl) begin
                                nPC <= JmplTarget;
                            end else if (IR[31:30] == OP_CALL) begin
                                nPC <= target;
                            end else begin
                                nPC        <= br_taken ? target : seq_npc;
                                annul_pend <= br_annul;
                            end
                        end
                    end
                end
                ST_HALT: state <= ST_HALT;
                default: state <= ST_START;
            endcase
        end
    end

endmodule
